sonar_scheduler: RTL
====================

# sonar_scheduler

Measurement sequencer for the ultrasonic distance sensor used in the NeuroSync game stage. On a start request it repeatedly fires the trigger pulse, times the echo, converts the width to rounded centimetres, and compares each reading with a target distance. It asserts `acerto` after a configurable number of consecutive in-tolerance readings. It sits between the main game FSM (start/abort/target in, acerto out) and the sensor pins (trigger/echo), and exposes the last reading for the hex displays and the serial reporter.

## Interface
- `TRIG_CYCLES`, 500: trigger pulse width in clocks (10 µs at 50 MHz).
- `CM_CYCLES`, 2941: clocks per centimetre of echo (58.82 µs).
- `TIMEOUT_CYCLES`, 1_500_000: maximum wait for echo rise, and maximum echo width (30 ms).
- `PERIOD_CYCLES`, 3_000_000: minimum spacing between consecutive trigger rises (60 ms).
- `HITS`, 3: consecutive in-tolerance readings required for `acerto`.
- `TOL_CM`, 2: allowed |reading − target| in cm.

- `clock`, in, 1: 50 MHz system clock. This is the only clock.
- `reset`, in, 1: synchronous reset, active-low.
- `start`, in, 1: single-cycle pulse that begins a session. Accepted in IDLE and DONE only.
- `abort`, in, 1: level signal. Returns the block to IDLE and takes priority over `start`.
- `target_cm`, in, 9: target distance. Sampled on an accepted `start`.
- `echo`, in, 1: asynchronous sensor echo. Synchronised internally with 2 flip-flops.
- `trigger`, out, 1: sensor trigger pulse.
- `medida_cm`, out, 9: last rounded reading. Holds its value between updates.
- `medida_valida`, out, 1: one-cycle pulse whenever `medida_cm` updates.
- `timeout`, out, 1: one-cycle pulse when a measurement times out.
- `acerto`, out, 1: success level. Held in DONE.
- `ocupado`, out, 1: high in every state except IDLE and DONE.
- `db_estado`, out, 4: state code for debug.

## Operation
- States and `db_estado` codes: IDLE 0, TRIGGER 1, WAIT_ECHO 2, MEASURE 3, EVAL 4, WAIT_PERIOD 5, DONE 6.
- Reset (`reset`=0 at a clock edge):
  - State goes to IDLE.
  - All outputs are 0, including `medida_cm`.
  - Hit counter and all timers are cleared.
- IDLE or DONE with `start`=1 and `abort`=0:
  - Latch `target_cm`, clear the hit counter, clear `acerto`.
  - Go to TRIGGER.
- TRIGGER:
  - `trigger`=1 for exactly `TRIG_CYCLES` cycles.
  - The period timer starts at entry.
  - Then go to WAIT_ECHO.
- WAIT_ECHO:
  - On a rising edge of synchronised echo, go to MEASURE.
  - After `TIMEOUT_CYCLES` cycles without a rise: pulse `timeout`, clear hits, go to WAIT_PERIOD.
- MEASURE:
  - A sub-counter counts to `CM_CYCLES`-1 and wraps. Each wrap increments the cm counter, which saturates at 511.
  - On a falling edge of synchronised echo, go to EVAL.
  - If the width reaches `TIMEOUT_CYCLES`: pulse `timeout`, clear hits, go to WAIT_PERIOD, and do not update `medida_cm`.
- EVAL (one cycle):
  - Rounding: `medida_cm` = cm count + (remainder ≥ `CM_CYCLES`/2 ? 1 : 0), saturated at 511.
  - Pulse `medida_valida`.
  - If |medida − target| ≤ `TOL_CM`, increment hits; otherwise set hits to 0.
  - If hits reaches `HITS`, go to DONE with `acerto`=1. Otherwise go to WAIT_PERIOD.
- WAIT_PERIOD: when the period timer reaches `PERIOD_CYCLES`, go to TRIGGER. If it has already expired, go to TRIGGER the next cycle.
- DONE: hold `acerto`=1 and `medida_cm`. Leave only on `start` (re-session) or `abort`.
- `abort`=1 in any state:
  - Next state is IDLE; `trigger`, `acerto`, and the hit counter drop to 0.
  - `medida_cm` is kept.
  - Any in-flight measurement produces no `medida_valida` or `timeout`.
- `start` while `ocupado`=1 is ignored.
- Simultaneous echo fall and the width-timeout count: the timeout wins.

## Timing
- `start` sampled at edge N: `trigger` rises after edge N+1.
- Echo synchroniser latency is 2 cycles on both edges, so the measured width equals the pin width ±1 cycle.
- `medida_valida` is asserted in the cycle after the synchronised echo fall is detected.
- `acerto` rises on the same edge that DONE is entered, i.e. 1 cycle after the final `medida_valida`.
- Trigger rises are spaced `max(PERIOD_CYCLES, actual measurement time)` apart.
- All outputs are registered.

## Test plan
- Reset values: hold `reset`=0 for 2 cycles, then release. Required: all outputs 0, `db_estado`=0, `trigger` stays low with no `start`.
- Correct distance: `target_cm`=75, `start`, answer each trigger with a 4399 µs echo three times. Required:
  - `medida_cm`=75 on each of the 3 `medida_valida` pulses.
  - `acerto`=1 one cycle after the 3rd pulse; `db_estado`=6; `ocupado`=0.
- Wrong then correct: target 75, echo widths 5882, 5882, 4399, 4399, 4399 µs. Required:
  - Readings 100, 100, 75, 75, 75.
  - `acerto` is asserted only after the 5th reading.
- Rounding: 5899 µs reads 100 (truncated); 4353 µs reads 74; 4399 µs reads 75 (rounded up).
- Timeout: `start` with no echo. Required:
  - `timeout` pulses `TIMEOUT_CYCLES` cycles after `trigger` falls.
  - The next `trigger` rise comes `PERIOD_CYCLES` cycles after the previous rise.
  - Hits are cleared, and `acerto` needs 3 further good readings.
- Abort mid-echo: assert `abort` 1000 µs into a 4399 µs echo. Required:
  - IDLE on the next cycle.
  - No `medida_valida` or `timeout` pulse.
  - `medida_cm` unchanged.
  - A following `start` restarts cleanly.

Source files
------------

// File: rtl/sonar_if.sv
// sonar_if -- signal bundle between the sonar measurement sequencer, the game
// FSM (start/abort/target_cm in, acerto out) and the ultrasonic sensor pins
// (trigger out, echo in).
//   slave  : seen by sonar_scheduler
//   master : seen by the driving side (game FSM / sensor / testbench)
// Signals:
//   start         game -> sched  one-cycle session start request
//   abort         game -> sched  level, forces IDLE
//   target_cm     game -> sched  target distance, latched on accepted start
//   echo          pin  -> sched  asynchronous sensor echo
//   trigger       sched -> pin   sensor trigger pulse
//   medida_cm     sched -> out   last rounded reading in cm
//   medida_valida sched -> out   one-cycle pulse on reading update
//   timeout       sched -> out   one-cycle pulse on measurement timeout
//   acerto        sched -> game  success level
//   ocupado       sched -> game  busy (not IDLE/DONE)
//   db_estado     sched -> out   state code for debug displays
interface sonar_if;
    logic       start;
    logic       abort;
    logic [8:0] target_cm;
    logic       echo;
    logic       trigger;
    logic [8:0] medida_cm;
    logic       medida_valida;
    logic       timeout;
    logic       acerto;
    logic       ocupado;
    logic [3:0] db_estado;

    modport slave (
        input  start, abort, target_cm, echo,
        output trigger, medida_cm, medida_valida, timeout, acerto, ocupado, db_estado
    );

    modport master (
        output start, abort, target_cm, echo,
        input  trigger, medida_cm, medida_valida, timeout, acerto, ocupado, db_estado
    );
endinterface

// File: rtl/sonar_scheduler.sv
// sonar_scheduler -- ultrasonic distance measurement sequencer.
// On start it repeatedly fires the trigger, times the echo, converts the width
// to rounded centimetres and compares each reading with the target distance.
// After HITS consecutive in-tolerance readings it parks in DONE with acerto=1.
// Ports:
//   clock : system clock (only clock)
//   reset : synchronous reset, active low
//   bus   : sonar_if.slave (start/abort/target_cm/echo in;
//           trigger/medida_cm/medida_valida/timeout/acerto/ocupado/db_estado out)
// All outputs are registered.
module sonar_scheduler #(
    parameter int TRIG_CYCLES    = 500,
    parameter int CM_CYCLES      = 2941,
    parameter int TIMEOUT_CYCLES = 1_500_000,
    parameter int PERIOD_CYCLES  = 3_000_000,
    parameter int HITS           = 3,
    parameter int TOL_CM         = 2
) (
    input logic    clock,
    input logic    reset,
    sonar_if.slave bus
);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 2);
    localparam int PER_W = $clog2(PERIOD_CYCLES + 1);
    localparam int SUB_W = $clog2(CM_CYCLES + 1);
    localparam int HIT_W = $clog2(HITS + 1);

    typedef enum logic [3:0] {
        S_IDLE        = 4'd0,
        S_TRIGGER     = 4'd1,
        S_WAIT_ECHO   = 4'd2,
        S_MEASURE     = 4'd3,
        S_EVAL        = 4'd4,
        S_WAIT_PERIOD = 4'd5,
        S_DONE        = 4'd6
    } state_t;

    state_t             r_state, w_state_nx;
    logic [TMR_W-1:0]   r_tmr;       // cycles spent in the current state
    logic [PER_W-1:0]   r_per;       // cycles since the last TRIGGER entry
    logic [SUB_W-1:0]   r_sub;       // echo width modulo CM_CYCLES
    logic [8:0]         r_cm;        // whole centimetres of echo width
    logic [HIT_W-1:0]   r_hits;
    logic [8:0]         r_target;
    logic [8:0]         r_medida;
    logic               r_echo_s1, r_echo_s2, r_echo_d;
    logic               r_trigger, r_valid, r_timeout, r_acerto, r_ocupado;

    logic               w_echo_rise, w_echo_fall;
    logic               w_sub_wrap, w_round_up;
    logic [SUB_W-1:0]   w_sub_nx;
    logic [8:0]         w_cm_nx;
    logic [9:0]         w_cm_sum;
    logic [8:0]         w_rounded;
    logic [8:0]         w_diff;
    logic               w_in_tol;
    logic [HIT_W-1:0]   w_hits_nx;
    logic               w_hit_done;
    logic               w_per_done;
    logic               w_start_ok, w_to_ev, w_meas_ev;

    // Two-flop synchroniser plus one delay stage for edge detection.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_echo_s1 <= 1'b0;
            r_echo_s2 <= 1'b0;
            r_echo_d  <= 1'b0;
        end else begin
            r_echo_s1 <= bus.echo;
            r_echo_s2 <= r_echo_s1;
            r_echo_d  <= r_echo_s2;
        end
    end

    assign w_echo_rise = r_echo_s2 & ~r_echo_d;
    assign w_echo_fall = ~r_echo_s2 & r_echo_d;

    // Width counters as they will be after this cycle; the fall cycle itself
    // is part of the echo, so rounding works on these values.
    assign w_sub_wrap = (r_sub == SUB_W'(CM_CYCLES - 1));
    assign w_sub_nx   = w_sub_wrap ? '0 : r_sub + SUB_W'(1);
    assign w_cm_nx    = (w_sub_wrap && r_cm != 9'd511) ? r_cm + 9'd1 : r_cm;
    assign w_round_up = (w_sub_nx >= SUB_W'(CM_CYCLES / 2));
    assign w_cm_sum   = {1'b0, w_cm_nx} + {9'd0, w_round_up};
    assign w_rounded  = w_cm_sum[9] ? 9'd511 : w_cm_sum[8:0];

    assign w_diff     = (r_medida >= r_target) ? r_medida - r_target : r_target - r_medida;
    assign w_in_tol   = (w_diff <= 9'(TOL_CM));
    assign w_hits_nx  = w_in_tol ? r_hits + HIT_W'(1) : '0;
    assign w_hit_done = (w_hits_nx >= HIT_W'(HITS));

    assign w_per_done = (r_per == PER_W'(PERIOD_CYCLES - 1));

    // Next state and single-cycle events. Abort overrides everything, so no
    // event can fire in the cycle it is sampled.
    always_comb begin
        w_state_nx = r_state;
        w_start_ok = 1'b0;
        w_to_ev    = 1'b0;
        w_meas_ev  = 1'b0;
        if (bus.abort) begin
            w_state_nx = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        w_state_nx = S_TRIGGER;
                        w_start_ok = 1'b1;
                    end
                end
                S_TRIGGER: begin
                    if (r_tmr == TMR_W'(TRIG_CYCLES - 1))
                        w_state_nx = S_WAIT_ECHO;
                end
                S_WAIT_ECHO: begin
                    // The pin trigger lags this state by one cycle, so the
                    // wait is TIMEOUT_CYCLES from the visible trigger fall.
                    if (w_echo_rise) begin
                        w_state_nx = S_MEASURE;
                    end else if (r_tmr == TMR_W'(TIMEOUT_CYCLES)) begin
                        w_state_nx = S_WAIT_PERIOD;
                        w_to_ev    = 1'b1;
                    end
                end
                S_MEASURE: begin
                    // Width timeout beats a simultaneous echo fall.
                    if (r_tmr == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                        w_state_nx = S_WAIT_PERIOD;
                        w_to_ev    = 1'b1;
                    end else if (w_echo_fall) begin
                        w_state_nx = S_EVAL;
                        w_meas_ev  = 1'b1;
                    end
                end
                S_EVAL: begin
                    w_state_nx = w_hit_done ? S_DONE : S_WAIT_PERIOD;
                end
                S_WAIT_PERIOD: begin
                    if (w_per_done)
                        w_state_nx = S_TRIGGER;
                end
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_tmr     <= '0;
            r_per     <= '0;
            r_sub     <= '0;
            r_cm      <= '0;
            r_hits    <= '0;
            r_target  <= '0;
            r_medida  <= '0;
            r_trigger <= 1'b0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            r_acerto  <= 1'b0;
            r_ocupado <= 1'b0;
        end else begin
            r_state <= w_state_nx;

            if (w_state_nx != r_state)
                r_tmr <= '0;
            else if (r_tmr != '1)
                r_tmr <= r_tmr + TMR_W'(1);

            // Period reference is the TRIGGER entry; saturates once expired.
            if (w_state_nx == S_TRIGGER && r_state != S_TRIGGER)
                r_per <= '0;
            else if (!w_per_done)
                r_per <= r_per + PER_W'(1);

            if (r_state != S_MEASURE) begin
                r_sub <= '0;
                r_cm  <= '0;
            end else begin
                r_sub <= w_sub_nx;
                r_cm  <= w_cm_nx;
            end

            if (bus.abort || w_start_ok || w_to_ev)
                r_hits <= '0;
            else if (r_state == S_EVAL)
                r_hits <= w_hits_nx;

            if (w_start_ok)
                r_target <= bus.target_cm;
            if (w_meas_ev)
                r_medida <= w_rounded;

            // Trigger is the registered TRIGGER decode (one cycle behind the
            // state), dropped immediately on abort.
            r_trigger <= (r_state == S_TRIGGER) && !bus.abort;
            r_valid   <= w_meas_ev;
            r_timeout <= w_to_ev;
            r_acerto  <= (w_state_nx == S_DONE);
            r_ocupado <= !(w_state_nx == S_IDLE || w_state_nx == S_DONE);
        end
    end

    assign bus.trigger       = r_trigger;
    assign bus.medida_cm     = r_medida;
    assign bus.medida_valida = r_valid;
    assign bus.timeout       = r_timeout;
    assign bus.acerto        = r_acerto;
    assign bus.ocupado       = r_ocupado;
    assign bus.db_estado     = r_state;

endmodule
